transmitter: RTL
================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 SHALL provide parameter DBIT, default 8: number of data bits per frame, valid range 5..8.
REQ-002 SHALL provide parameter SB_TICK, default 16: stop-bit length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port s_tick, input, 1 bit: one-clk oversampling pulse from the baud-rate generator, 16 per bit period.
REQ-006 SHALL provide port tx_start, input, 1 bit: one-clk request to send din.
REQ-007 SHALL provide port din, input, DBIT bits: data to send; sampled only when tx_start is accepted.
REQ-008 SHALL provide port tx, output, 1 bit: serial line, registered, idle high.
REQ-009 SHALL provide port tx_busy, output, 1 bit: high whenever the state is not idle.
REQ-010 SHALL provide port tx_done_tick, output, 1 bit: one-clk pulse at frame completion.

Function
REQ-011 SHALL use a four-state FSM: idle, start, data, stop.
REQ-012 SHALL keep the following registers:
- s_reg, 5 bits: tick counter
- n_reg, 3 bits: bit counter
- b_reg, DBIT bits: shift register
- tx_reg: drives tx
REQ-013 SHALL, in idle with tx_start=1 on any clk edge (s_tick not required), load b_reg from din, clear s_reg, enter start, and drive tx=0 from the next edge.
REQ-014 SHALL ignore tx_start while not idle, leaving din unsampled and the frame unaffected.
REQ-015 SHALL increment s_reg only on clk edges where s_tick=1, and otherwise hold all counters.
REQ-016 SHALL, in start, hold tx=0, and on the s_tick where s_reg=15: clear s_reg, clear n_reg, enter data, and drive tx=b_reg[0].
REQ-017 SHALL, in data, send bits LSB first, each held for 16 s_tick pulses. On the s_tick where s_reg=15: clear s_reg, shift b_reg right by 1, and either increment n_reg or, if n_reg=DBIT-1, enter stop with tx=1.
REQ-018 SHALL, in stop, hold tx=1. On the s_tick where s_reg=SB_TICK-1: enter idle and assert tx_done_tick for exactly the next clk cycle.
REQ-019 SHALL accept a tx_start that arrives in the same cycle as tx_done_tick=1 (state already idle), giving back-to-back frames with no gap beyond the stop bit.
REQ-020 SHALL treat an s_tick coincident with tx_start acceptance as not counted; counting begins at the first s_tick after entering start.
REQ-021 SHALL keep tx glitch-free: tx changes only at bit boundaries and is driven directly from a flop.
REQ-022 SHALL return any unused or illegal state to idle on the next clk, with tx=1.

Reset
REQ-023 SHALL, when rst_n=0, immediately and asynchronously set: state=idle, tx=1, tx_busy=0, tx_done_tick=0, s_reg=0, n_reg=0, b_reg=0.
REQ-024 SHALL, on reset asserted mid-frame, abandon the frame (no tx_done_tick) and force tx high at once. After release it SHALL wait in idle for a new tx_start.
REQ-025 SHALL leave idle only on the first clk edge after rst_n deasserts on which tx_start=1.

Verification
REQ-026 SHALL check a basic frame: with s_tick every 4 clk, DBIT=8, SB_TICK=16, din=0xA5 and a tx_start pulse. Required line sequence, each bit 16 ticks: tx 0 (start), then 1,0,1,0,0,1,0,1, then 1 for 16 ticks. tx_done_tick pulses once, and tx_busy is high from the cycle after tx_start through the last stop tick.
REQ-027 SHALL check busy rejection: a tx_start with din=0x3C during the data phase of a 0xFF frame. Required: the line still carries 0xFF, with one tx_done_tick only.
REQ-028 SHALL check back-to-back frames: tx_start with din=0x55 asserted in the tx_done_tick cycle of a 0x00 frame. Required: the new start bit begins on the next clk, with no idle gap.
REQ-029 SHALL check reset mid-frame: rst_n=0 during bit 3 of 0x81. Required: tx=1 immediately, no tx_done_tick; after release, a 0x81 frame sent afresh is correct.
REQ-030 SHALL check parameter variants: DBIT=7, SB_TICK=32, din=0x41. Required: 7 data bits 1,0,0,0,0,0,1, a stop bit of 32 ticks, then tx_done_tick.
REQ-031 SHALL check idle quiet: s_tick toggling with no tx_start for 1000 clk. Required: tx=1, tx_busy=0, tx_done_tick=0 throughout.

Source files
------------

// File: rtl/transmitter.sv
// UART serial transmitter: start bit, DBIT data bits LSB first, SB_TICK-tick stop bit.
// Timing is paced by a 16x oversampling s_tick from an external baud-rate generator.
module transmitter #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t          state_r;
  logic [4:0]      s_reg;
  logic [2:0]      n_reg;
  logic [DBIT-1:0] b_reg;
  logic            tx_reg;
  logic            busy_r;
  logic            done_r;

  // Frame sequencer; every output is a flop so tx never glitches between bit boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      s_reg   <= 5'd0;
      n_reg   <= 3'd0;
      b_reg   <= '0;
      tx_reg  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_reg <= 1'b1;
          busy_r <= 1'b0;
          // A tick on the accepting edge is deliberately not counted.
          if (tx_start) begin
            b_reg   <= din;
            s_reg   <= 5'd0;
            state_r <= START;
            tx_reg  <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        START: begin
          if (s_tick) begin
            if (s_reg == 5'd15) begin
              s_reg   <= 5'd0;
              n_reg   <= 3'd0;
              state_r <= DATA;
              tx_reg  <= b_reg[0];
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end else begin
            s_reg <= s_reg;
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_reg == 5'd15) begin
              s_reg <= 5'd0;
              b_reg <= b_reg >> 1;
              if (n_reg == 3'(DBIT - 1)) begin
                state_r <= STOP;
                tx_reg  <= 1'b1;
              end else begin
                n_reg  <= n_reg + 3'd1;
                tx_reg <= b_reg[1];
              end
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end else begin
            s_reg <= s_reg;
          end
        end

        STOP: begin
          tx_reg <= 1'b1;
          if (s_tick) begin
            if (s_reg == 5'(SB_TICK - 1)) begin
              s_reg   <= 5'd0;
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end else begin
            s_reg <= s_reg;
          end
        end

        default: begin
          state_r <= IDLE;
          tx_reg  <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx           = tx_reg;
  assign tx_busy      = busy_r;
  assign tx_done_tick = done_r;

endmodule
